// File: rtl/avg_pool_div_seq.sv
// Average-pooling front end for the fixed-point serial divider.
// Sums one window of sign-magnitude samples and divides by its length.
module avg_pool_div_seq #(
  parameter int N     = 32,
  parameter int Q     = 15,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_last,
  output logic [N-1:0] div_dividend,
  output logic [N-1:0] div_divisor,
  output logic         div_start,
  input  logic [N-1:0] div_quotient,
  input  logic         div_complete,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sat
);

  localparam int AW = N + CNT_W;
  localparam int PADW = N - CNT_W - Q;

  typedef enum logic [2:0] {
    S_ACC,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [N-1:0]     dvd_q, dvd_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [N-1:0]     odata_q, odata_d;
  logic             osat_q, osat_d;

  logic [AW-1:0]    in_ext;
  logic [AW-1:0]    acc_sum;
  logic [AW-1:0]    sum_abs;
  logic             sum_neg;
  logic             sum_big;
  logic [N-2:0]     sum_mag;
  logic [CNT_W-1:0] cnt_inc;
  logic             close;

  // Sign-magnitude to two's complement; -0 negates to 0.
  always_comb begin
    in_ext = {{(CNT_W+1){1'b0}}, in_data[N-2:0]};
    if (in_data[N-1]) begin
      in_ext = -in_ext;
    end
  end

  assign acc_sum = acc_q + in_ext;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign close   = in_last || (cnt_inc == '1);

  // Window sum back to sign-magnitude with clamping.
  assign sum_neg = acc_sum[AW-1];
  assign sum_abs = sum_neg ? -acc_sum : acc_sum;
  assign sum_big = |sum_abs[AW-1:N-1];
  assign sum_mag = sum_big ? '1 : sum_abs[N-2:0];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    odata_d   = odata_q;
    osat_d    = osat_q;
    in_ready  = 1'b0;
    div_start = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (close) begin
            dvd_d   = {sum_neg, sum_mag};
            dvs_d   = {{PADW{1'b0}}, cnt_inc, {Q{1'b0}}};
            sat_d   = sum_big;
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        // Divider may still be running a stale op.
        div_start = div_complete;
        if (div_complete) begin
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!div_complete) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (div_complete) begin
          odata_d = div_quotient;
          osat_d  = sat_q;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = S_ACC;
        end
      end
      default: begin
        state_d = S_ACC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      odata_q <= '0;
      osat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      odata_q <= odata_d;
      osat_q  <= osat_d;
    end
  end

  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;
  assign out_data     = odata_q;
  assign out_sat      = osat_q;

  a_cnt_nonzero: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q == S_LAUNCH) |-> (cnt_q != '0)
  );

  a_operands_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state_q != S_ACC) |=> $stable(dvd_q) && $stable(dvs_q)
  );

  a_out_hold: assert property (
    @(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> out_valid && $stable(odata_q)
  );

endmodule

// File: tb/tb_avg_pool_div_seq.sv
// Directed bench for avg_pool_div_seq with a behavioural
// serial-divider model that ignores reset.
module tb_avg_pool_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_start;
  logic [31:0] div_quotient = '0;
  logic        div_complete;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;

  int passes = 0;
  int checks = 0;

  logic        busy = 1'b0;
  logic        hold = 1'b0;
  int          dcnt = 0;
  logic [31:0] dres = '0;
  int          start_cnt = 0;
  logic [31:0] cap_dvd = '0;
  logic [31:0] cap_dvs = '0;

  always #5 clk = ~clk;

  avg_pool_div_seq #(.N(32), .Q(15), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .div_dividend(div_dividend),
    .div_divisor(div_divisor),
    .div_start(div_start),
    .div_quotient(div_quotient),
    .div_complete(div_complete),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_sat(out_sat)
  );

  function automatic logic [31:0] qdiv(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] num;
    logic [63:0] den;
    logic [63:0] q;
    num = {33'd0, a[30:0]} << 15;
    den = {33'd0, b[30:0]};
    q = (den == 0) ? '1 : num / den;
    return {a[31] ^ b[31], q[30:0]};
  endfunction

  assign div_complete = !busy && !hold;

  // Divider: busy N+Q-1 = 46 cycles after accepting start.
  always @(posedge clk) begin
    if (busy) begin
      if (dcnt == 1) begin
        busy <= 1'b0;
        div_quotient <= dres;
      end
      dcnt <= dcnt - 1;
    end else if (div_start && div_complete) begin
      busy <= 1'b1;
      dcnt <= 46;
      dres <= qdiv(div_dividend, div_divisor);
      start_cnt <= start_cnt + 1;
      cap_dvd <= div_dividend;
      cap_dvs <= div_divisor;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    while (!in_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_ready: got in_ready=0 want 1");
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int t = 0;
    while (!out_valid && t < 400) begin
      @(negedge clk);
      t++;
    end
    ok = out_valid;
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL rst_in_ready: got %b want 1", in_ready);
    else passes++;
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_out_valid: got %b want 0", out_valid);
    else passes++;
    checks++;
    if (div_start !== 1'b0)
      $display("FAIL rst_div_start: got %b want 0", div_start);
    else passes++;
    checks++;
    if ({div_dividend, div_divisor} !== 64'd0)
      $display("FAIL rst_div_ops: got %h %h want 0 0",
               div_dividend, div_divisor);
    else passes++;
    checks++;
    if ({out_data, out_sat} !== 33'd0)
      $display("FAIL rst_out: got %h %b want 0 0", out_data, out_sat);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL rst_release_ready: got %b want 1", in_ready);
    else passes++;
  endtask

  task automatic test_basic();
    bit ok;
    send(32'h0000_8000, 1'b0);
    send(32'h0001_0000, 1'b0);
    send(32'h0001_8000, 1'b1);
    wait_out(ok);
    checks++;
    if (!ok) $display("FAIL basic_timeout: got no out_valid want 1");
    else passes++;
    checks++;
    if (cap_dvd !== 32'h0003_0000 || cap_dvs !== 32'h0001_8000)
      $display("FAIL basic_ops: got %h/%h want 00030000/00018000",
               cap_dvd, cap_dvs);
    else passes++;
    checks++;
    if (out_data !== 32'h0001_0000 || out_sat !== 1'b0)
      $display("FAIL basic_out: got %h sat %b want 00010000 sat 0",
               out_data, out_sat);
    else passes++;
    ack();
  endtask

  task automatic test_negative();
    bit ok;
    send(32'h8000_C000, 1'b0);
    send(32'h0000_4000, 1'b1);
    wait_out(ok);
    checks++;
    if (cap_dvd !== 32'h8000_8000 || cap_dvs !== 32'h0001_0000)
      $display("FAIL neg_ops: got %h/%h want 80008000/00010000",
               cap_dvd, cap_dvs);
    else passes++;
    checks++;
    if (!ok || out_data !== 32'h8000_4000 || out_sat !== 1'b0)
      $display("FAIL neg_out: got %h sat %b want 80004000 sat 0",
               out_data, out_sat);
    else passes++;
    ack();
  endtask

  task automatic test_sat();
    bit ok;
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h7FFF_FFFF, 1'b1);
    wait_out(ok);
    checks++;
    if (cap_dvd !== 32'h7FFF_FFFF || cap_dvs !== 32'h0001_0000)
      $display("FAIL sat_ops: got %h/%h want 7fffffff/00010000",
               cap_dvd, cap_dvs);
    else passes++;
    checks++;
    if (!ok || out_data !== 32'h3FFF_FFFF || out_sat !== 1'b1)
      $display("FAIL sat_out: got %h sat %b want 3fffffff sat 1",
               out_data, out_sat);
    else passes++;
    ack();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL sat_after_ack: got rdy %b vld %b want 1 0",
               in_ready, out_valid);
    else passes++;
  endtask

  task automatic test_forced_close();
    bit ok;
    for (int i = 0; i < 255; i++) send(32'h0000_8000, 1'b0);
    checks++;
    if (in_ready !== 1'b0)
      $display("FAIL force_closed: got in_ready %b want 0", in_ready);
    else passes++;
    wait_out(ok);
    checks++;
    if (in_ready !== 1'b0)
      $display("FAIL force_ready_out: got %b want 0", in_ready);
    else passes++;
    checks++;
    if (cap_dvd !== 32'h007F_8000 || cap_dvs !== 32'h007F_8000)
      $display("FAIL force_ops: got %h/%h want 007f8000/007f8000",
               cap_dvd, cap_dvs);
    else passes++;
    checks++;
    if (!ok || out_data !== 32'h0000_8000 || out_sat !== 1'b0)
      $display("FAIL force_out: got %h sat %b want 00008000 sat 0",
               out_data, out_sat);
    else passes++;
    ack();
  endtask

  task automatic test_backpressure();
    bit ok;
    int s0;
    int bad;
    hold = 1'b1;
    send(32'h0000_8000, 1'b1);
    s0 = start_cnt;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (div_start !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0 || start_cnt != s0)
      $display("FAIL hold_nostart: got %0d highs want 0", bad);
    else passes++;
    hold = 1'b0;
    #1;
    checks++;
    if (div_start !== 1'b1)
      $display("FAIL hold_release_start: got %b want 1", div_start);
    else passes++;
    @(negedge clk);
    checks++;
    if (div_start !== 1'b0 || start_cnt != s0 + 1)
      $display("FAIL start_pulse: got %b n=%0d want 0 n=%0d",
               div_start, start_cnt - s0, 1);
    else passes++;
    wait_out(ok);
    checks++;
    if (!ok || out_data !== 32'h0000_8000)
      $display("FAIL bp_out: got %h want 00008000", out_data);
    else passes++;
    in_valid = 1'b1;
    in_data  = 32'h0010_0000;
    in_last  = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 32'h0000_8000 ||
          in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checks++;
    if (bad != 0)
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    else passes++;
    ack();
    send(32'h0001_0000, 1'b1);
    wait_out(ok);
    checks++;
    if (!ok || out_data !== 32'h0001_0000)
      $display("FAIL bp_next: got %h want 00010000", out_data);
    else passes++;
    ack();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int t = 0;
    send(32'h0000_8000, 1'b0);
    send(32'h0001_0000, 1'b1);
    while (div_complete && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        div_start !== 1'b0)
      $display("FAIL mid_rst_ctl: got %b%b%b want 100",
               in_ready, out_valid, div_start);
    else passes++;
    checks++;
    if ({div_dividend, div_divisor, out_data} !== 96'd0 ||
        out_sat !== 1'b0)
      $display("FAIL mid_rst_data: got %h %h %h want 0",
               div_dividend, div_divisor, out_data);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'h0002_0000, 1'b0);
    send(32'h0001_0000, 1'b1);
    checks++;
    if (div_start !== 1'b0 || div_complete !== 1'b0)
      $display("FAIL mid_stale_wait: got start %b cmpl %b want 0 0",
               div_start, div_complete);
    else passes++;
    wait_out(ok);
    checks++;
    if (cap_dvd !== 32'h0003_0000 || cap_dvs !== 32'h0001_0000)
      $display("FAIL mid_ops: got %h/%h want 00030000/00010000",
               cap_dvd, cap_dvs);
    else passes++;
    checks++;
    if (!ok || out_data !== 32'h0001_8000 || out_sat !== 1'b0)
      $display("FAIL mid_out: got %h sat %b want 00018000 sat 0",
               out_data, out_sat);
    else passes++;
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_sat();
    test_forced_close();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
